// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, funct3 codes and access legality check for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_C, OWN_D} owner_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic access_ok(input logic we, input logic [2:0] funct3, input logic [1:0] a);
    return (we ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W)
               : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || funct3 == F3_BU || funct3 == F3_HU))
        && ((funct3 == F3_H || funct3 == F3_HU) ? !a[0] : funct3 == F3_W ? a == 2'b00 : 1'b1);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, last grant updated on accept
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_c,
  input  logic   req_d,
  input  logic   accept,
  output owner_e grant
);
  owner_e last_q, last_d;
  always_comb begin
    grant = (req_c && req_d) ? (last_q == OWN_C ? OWN_D : OWN_C) : req_d ? OWN_D : OWN_C;
    last_d = accept ? grant : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_D;
    else last_q <= last_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port data memory between core (C) and DMA (D) ports
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [2:0]        c_req_funct3,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  output logic              c_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_funct3,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, grant;
  logic we_q, we_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic c_rsp_q, c_rsp_d, d_rsp_q, d_rsp_d, rsp_err_q, rsp_err_d;
  logic open, accept, act, sel_we;
  logic [2:0] sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_c  (c_req_valid),
    .req_d  (d_req_valid),
    .accept (accept),
    .grant  (grant)
  );
  always_comb begin
    open = state_q != ACCESS;
    act = state_q == ACCESS;
    c_req_ready = open && grant == OWN_C;
    d_req_ready = open && grant == OWN_D;
    accept = (c_req_valid && c_req_ready) || (d_req_valid && d_req_ready);
    sel_we = grant == OWN_D ? d_req_we : c_req_we;
    sel_f3 = grant == OWN_D ? d_req_funct3 : c_req_funct3;
    sel_addr = grant == OWN_D ? d_req_addr : c_req_addr;
    sel_wdata = grant == OWN_D ? d_req_wdata : c_req_wdata;
    owner_d = accept ? grant : owner_q;
    we_d = accept ? sel_we : we_q;
    f3_d = accept ? sel_f3 : f3_q;
    addr_d = accept ? sel_addr : addr_q;
    wdata_d = accept ? sel_wdata : wdata_q;
    err_d = accept ? !access_ok(sel_we, sel_f3, sel_addr[1:0]) : err_q;
    state_d = accept ? (err_d ? RESP : ACCESS) : act ? RESP : IDLE;
    rdata_d = (act && !we_q) ? mem_rdata : '0;
    c_rsp_d = state_d == RESP && owner_d == OWN_C;
    d_rsp_d = state_d == RESP && owner_d == OWN_D;
    rsp_err_d = state_d == RESP && err_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_C;
      we_q <= 1'b0;
      err_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      c_rsp_q <= 1'b0;
      d_rsp_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      err_q <= err_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      c_rsp_q <= c_rsp_d;
      d_rsp_q <= d_rsp_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign c_rsp_valid = c_rsp_q;
  assign d_rsp_valid = d_rsp_q;
  assign c_rsp_err = c_rsp_q && rsp_err_q;
  assign d_rsp_err = d_rsp_q && rsp_err_q;
  assign c_rsp_rdata = c_rsp_q ? rdata_q : '0;
  assign d_rsp_rdata = d_rsp_q ? rdata_q : '0;
  assign mem_read = act && !we_q;
  assign mem_write = act && we_q;
  assign mem_funct3 = act ? f3_q : '0;
  assign mem_addr = act ? addr_q : '0;
  assign mem_wdata = act ? wdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter against a byte-level reference model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_err;
  logic [2:0] c_req_funct3;
  logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
  logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [2:0] d_req_funct3;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic mem_read, mem_write;
  logic [2:0] mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_funct3(c_req_funct3), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [0:1023];
  logic [31:0] m_cur, m_sh, m_mask;
  logic [4:0] m_amt;
  always_comb begin
    m_cur = mem[mem_addr[11:2]];
    m_amt = {mem_addr[1:0], 3'b000};
    m_sh = m_cur >> m_amt;
    m_mask = mem_funct3[1:0] == 2'd0 ? 32'hFF : mem_funct3[1:0] == 2'd1 ? 32'hFFFF : 32'hFFFFFFFF;
    mem_rdata = mem_funct3[1:0] == 2'd2 ? m_sh
              : mem_funct3[1:0] == 2'd1 ? (mem_funct3[2] ? {16'h0, m_sh[15:0]} : {{16{m_sh[15]}}, m_sh[15:0]})
              : (mem_funct3[2] ? {24'h0, m_sh[7:0]} : {{24{m_sh[7]}}, m_sh[7:0]});
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    else if (mem_write) mem[mem_addr[11:2]] <= (m_cur & ~(m_mask << m_amt)) | ((mem_wdata & m_mask) << m_amt);
  end
  int n_run = 0, n_fail = 0, cyc = 0;
  int acc_at = -1, rsp_at = -1, rsp_port = 0, last_port = 1, acc_k = 0;
  logic acc_we, rsp_err, c_acc, d_acc;
  logic [2:0] acc_f3;
  logic [31:0] acc_addr, acc_wdata, rsp_data;
  logic [7:0] ref_b [0:4095];
  logic [31:0] seen_rdata [2];
  logic seen_err [2];
  int seen_at [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == 2'd3 || f3 == 3'b110 || (we && f3[2])) return 1'b0;
    return f3[1:0] == 2'd2 ? a == 2'd0 : f3[1:0] == 2'd1 ? !a[0] : 1'b1;
  endfunction
  function automatic logic [31:0] load_val(input logic [2:0] f3, input int a);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_b[(a + i) & 4095]) << (8 * i));
    if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFFFFFF << (8 * nb));
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4096; i++) ref_b[i] = 8'h0;
    acc_at = -1;
    rsp_at = -1;
    last_port = 1;
  endtask
  task automatic model_accept(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    last_port = p;
    rsp_port = p;
    acc_k = cyc;
    if (!legal(we, f3, a[1:0])) begin
      rsp_at = cyc + 1;
      rsp_data = 32'h0;
      rsp_err = 1'b1;
    end else begin
      acc_at = cyc + 1;
      rsp_at = cyc + 2;
      rsp_err = 1'b0;
      acc_we = we;
      acc_f3 = f3;
      acc_addr = a;
      acc_wdata = wd;
      rsp_data = 32'h0;
      if (we) for (int i = 0; i < (1 << f3[1:0]); i++) ref_b[(int'(a[11:0]) + i) & 4095] = wd[8 * i +: 8];
      else rsp_data = load_val(f3, int'(a[11:0]));
    end
  endtask
  task automatic chk_rsp(input int p, input logic v, input logic [31:0] d, input logic e);
    logic ev;
    string t;
    ev = rsp_at == cyc && rsp_port == p;
    t = p == 1 ? "d" : "c";
    chk({t, "_rsp_valid"}, v, ev);
    chk({t, "_rsp_rdata"}, d, ev ? rsp_data : 32'h0);
    chk({t, "_rsp_err"}, e, ev && rsp_err);
    if (v) begin
      seen_rdata[p] = d;
      seen_err[p] = e;
      seen_at[p] = cyc;
    end
  endtask
  task automatic cycle();
    logic act;
    int w;
    @(negedge clk);
    chk_rsp(0, c_rsp_valid, c_rsp_rdata, c_rsp_err);
    chk_rsp(1, d_rsp_valid, d_rsp_rdata, d_rsp_err);
    act = acc_at == cyc;
    chk("mem_read", mem_read, act && !acc_we);
    chk("mem_write", mem_write, act && acc_we);
    chk("mem_funct3", mem_funct3, act ? acc_f3 : 3'b0);
    chk("mem_addr", mem_addr, act ? acc_addr : 32'h0);
    chk("mem_wdata", mem_wdata, act ? acc_wdata : 32'h0);
    w = (c_req_valid && d_req_valid) ? 1 - last_port : d_req_valid ? 1 : 0;
    chk("c_req_ready", c_req_ready, !act && w == 0);
    chk("d_req_ready", d_req_ready, !act && w == 1);
    c_acc = !act && w == 0 && c_req_valid;
    d_acc = !act && w == 1 && d_req_valid;
    if (c_acc) model_accept(0, c_req_we, c_req_funct3, c_req_addr, c_req_wdata);
    if (d_acc) model_accept(1, d_req_we, d_req_funct3, d_req_addr, d_req_wdata);
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    if (p == 1) begin
      d_req_valid = v; d_req_we = we; d_req_funct3 = f3; d_req_addr = a; d_req_wdata = wd;
    end else begin
      c_req_valid = v; c_req_we = we; c_req_funct3 = f3; c_req_addr = a; c_req_wdata = wd;
    end
  endtask
  task automatic do_req(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic ok;
    ok = 1'b0;
    seen_at[p] = -1;
    drive(1 - p, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(p, 1'b1, we, f3, a, wd);
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = p == 1 ? d_acc : c_acc;
    end
    drive(p, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    chk("req_accept", ok, 1'b1);
    repeat (3) cycle();
    chk("rsp_latency", seen_at[p] - acc_k, exp_lat);
    chk("rsp_data", seen_rdata[p], exp_d);
    chk("rsp_err_flag", seen_err[p], exp_e);
  endtask
  initial begin
    int prev, first, n_acc, d_before;
    logic got;
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    model_reset();
    #12;
    chk("rst_c_rsp_valid", c_rsp_valid, 1'b0);
    chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("rst_c_rsp_rdata", c_rsp_rdata, 32'h0);
    chk("rst_d_rsp_err", d_rsp_err, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    do_req(1, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
    do_req(1, 1'b1, 3'b000, 32'h13, 32'h000000AB, 32'h0, 1'b0, 2);
    do_req(1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000AB, 1'b0, 2);
    do_req(1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    do_req(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hAB223344, 1'b0, 2);
    prev = -1;
    first = -1;
    n_acc = 0;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (c_acc || d_acc) begin
        if (first < 0) first = int'(d_acc);
        else chk("rr_alternate", d_acc, prev == 0);
        prev = int'(d_acc);
        n_acc++;
        drive(prev, 1'b1, 1'b0, 3'b010, 32'($urandom_range(0, 63) * 4), 32'h0);
      end
    end
    chk("rr_first_c", first, 0);
    chk("rr_rate", n_acc, 8);
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    do_req(0, 1'b1, 3'b001, 32'h21, 32'h1234, 32'h0, 1'b1, 1);
    do_req(0, 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1);
    do_req(0, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    repeat (5) cycle();
    drive(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    d_before = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (d_acc) d_before++;
      got = c_acc;
    end
    chk("no_starve", got, 1'b1);
    chk("starve_wait_le1", d_before <= 1, 1'b1);
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        drive(p, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom_range(0, 255)), $urandom);
      cycle();
    end
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    drive(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h55);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = c_acc;
    end
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    chk("rst_test_accept", got, 1'b1);
    @(negedge clk);
    chk("pre_rst_mem_write", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", mem_write, 1'b0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_mem_wdata", mem_wdata, 32'h0);
    chk("async_rst_c_rsp_valid", c_rsp_valid, 1'b0);
    chk("async_rst_d_rsp_valid", d_rsp_valid, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    seen_at[0] = -1;
    cycle();
    chk("post_rst_tie_c", c_acc, 1'b1);
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = d_acc;
    end
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    chk("post_rst_d_accept", got, 1'b1);
    chk("post_rst_lw_seen", seen_at[0] >= 0, 1'b1);
    chk("post_rst_lw_data", seen_rdata[0], 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the core load/store unit (port C) and the DMA/debug engine (port D). Each port uses a valid/ready request channel and a one-cycle response pulse. The block arbitrates round-robin, registers the winning request, and drives the memory's MemRead/MemWrite/funct3/addr/WriteData inputs for exactly one cycle. It returns load data, or an error for misaligned or illegal accesses, to the owning port.

Parameters:
ADDR_W, 32, byte-address width on both ports and toward memory
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
c_req_valid  in  1  port C request valid
c_req_ready  out  1  port C request accepted when valid&ready
c_req_we  in  1  1 = store, 0 = load
c_req_funct3  in  3  RISC-V width/sign code (instr[14:12])
c_req_addr  in  ADDR_W  byte address
c_req_wdata  in  DATA_W  store data, low-aligned
c_rsp_valid  out  1  one-cycle response pulse
c_rsp_rdata  out  DATA_W  load result; 0 for stores and errors
c_rsp_err  out  1  misaligned or illegal funct3; qualified by rsp_valid
d_req_valid, d_req_ready, d_req_we, d_req_funct3, d_req_addr, d_req_wdata, d_rsp_valid, d_rsp_rdata, d_rsp_err  same as port C, for port D
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_funct3  out  3  to memory funct3
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory WriteData
mem_rdata  in  DATA_W  from memory ReadData (combinational)

Behaviour:
- Reset, asynchronous: state=IDLE, last_grant=D (so C wins the first tie). All rsp_valid, rsp_err and rsp_rdata are 0. All mem_* outputs are 0. Latched request registers are 0.
- States: IDLE, ACCESS, RESP.
- Accept: x_req_ready = (state==IDLE || state==RESP) && grant==x. Ready depends combinationally on valid; no valid-on-ready dependency is allowed upstream.
- Arbitration: only C valid -> C. Only D valid -> D. Both valid -> the port not equal to last_grant. last_grant updates on accept only.
- Check at accept:
  - Load funct3 must be in {000,001,010,100,101}; store funct3 in {000,001,010}. Anything else is illegal.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - A failed check latches err=1.
- Accept edge: latch owner, we, funct3, addr, wdata, err. The next state is ACCESS, or RESP directly if err.
- ACCESS, one cycle: mem_read=!we, mem_write=we, mem_* = latched values. The memory commits the store at the end-of-cycle edge. Load data (mem_rdata) is captured into the rdata register at the same edge. Next state is RESP.
- Outside ACCESS, all mem_* outputs are 0. The memory is never enabled on an error request.
- RESP, one cycle: owner's rsp_valid=1, rsp_rdata=captured data (0 for store or err), rsp_err=err. The other port's rsp outputs stay 0.
  - If a new request is accepted in RESP, go to ACCESS (or RESP on err). Otherwise go to IDLE.
  - rsp outputs are registered, driven from state and owner registers, not combinational.
- Latency: accept edge -> rsp_valid two cycles later. Throughput is one access per 2 cycles (accept in RESP). The error path is one cycle from accept to response.
- Responders must accept the rsp pulse; there is no backpressure.
- Simultaneous events: a request arriving in ACCESS waits (ready=0). Inputs are sampled only at the accept edge, so changes after accept are ignored.
- Reset mid-operation: the state machine aborts, and a pending response is dropped. The memory is reset by the same rst_n.
- Address forwarded unmodified; memory word-indexes it (addr[11:2]).

Decomposition:
- Package dmem_arb_pkg contains:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_C, OWN_D}
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - function access_ok(we, funct3, addr[1:0]) returning the legality result
- Sub-module rr_arb2: two-requester round-robin with a last_grant flop updated on an accept strobe. All other logic stays in dmem_arbiter.

Test Plan:
- C store SW addr=0x10 wdata=0xDEADBEEF, then C load LW 0x10 -> c_rsp_valid two cycles after each accept; load c_rsp_rdata=0xDEADBEEF, err=0; d_rsp_valid stays 0.
- C and D both valid continuously with loads -> grants alternate C,D,C,D starting with C; each response arrives on the correct port; one accept every 2 cycles.
- D store SB addr=0x13 wdata=0x000000AB over word 0x11223344, then LBU 0x13 -> rdata=0x000000AB; LB 0x13 -> 0xFFFFFFAB; LW 0x10 -> 0xAB223344.
- C SH addr=0x21, C LW addr=0x22, C load funct3=011 -> each gives rsp_err=1, rdata=0, one cycle after accept; mem_read and mem_write never assert.
- Accept C store SW 0x30 wdata=0x55 and deassert rst_n during ACCESS -> all rsp and mem_* outputs go 0 asynchronously; after release, LW 0x30 returns 0 and the first tie goes to C.
- C valid held while D completes a long stream -> C is granted no later than the second accept opportunity (no starvation).
